// File: rtl/seg_dyn_scan.sv
// Six-digit multiplexed 7-segment driver with a sequential double-dabble BCD converter.
// Define SEG_DYN_ZERO_BLANK_EN to enable leading-zero blanking and the minus-sign digit.
`timescale 1ns/1ps
module seg_dyn_scan #(
    parameter logic [15:0] CNT_MAX = 16'd49_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        sign,
    input  logic        seg_en,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_t;

    localparam logic [19:0] DATA_MAX = 20'd999_999;

    conv_state_t state, state_next;
    logic [4:0]  iter;
    logic [19:0] bin;
    logic [23:0] bcd;
    logic [23:0] bcd_adj;
    logic [23:0] bcd_result;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic        scan_tick;
    logic [3:0]  digit;
    logic        dp;
    logic [5:0]  sel_next;
    logic [6:0]  body;

    function automatic logic [6:0] seg_code(input logic [3:0] value);
        case (value)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    assign scan_tick = (cnt == CNT_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (scan_tick) begin
            cnt <= '0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = SHIFT;
            SHIFT:   if (iter == 5'd19) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction on every nibble before each shift keeps the scratch in valid BCD.
    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < 6; n++) begin
            if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bin        <= '0;
            bcd        <= '0;
            iter       <= '0;
            bcd_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bin  <= (data > DATA_MAX) ? DATA_MAX : data;
                    bcd  <= '0;
                    iter <= '0;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    iter       <= iter + 5'd1;
                end
                LOAD:    bcd_result <= bcd;
                default: ;
            endcase
        end
    end

    always_comb begin
        digit    = 4'd0;
        dp       = 1'b0;
        sel_next = 6'b000000;
        case (idx)
            3'd0: begin digit = bcd_result[3:0];   dp = point[0]; sel_next = 6'b000001; end
            3'd1: begin digit = bcd_result[7:4];   dp = point[1]; sel_next = 6'b000010; end
            3'd2: begin digit = bcd_result[11:8];  dp = point[2]; sel_next = 6'b000100; end
            3'd3: begin digit = bcd_result[15:12]; dp = point[3]; sel_next = 6'b001000; end
            3'd4: begin digit = bcd_result[19:16]; dp = point[4]; sel_next = 6'b010000; end
            3'd5: begin digit = bcd_result[23:20]; dp = point[5]; sel_next = 6'b100000; end
            default: ;
        endcase
    end

`ifdef SEG_DYN_ZERO_BLANK_EN
    logic [2:0] msd;

    // msd is the most significant nonzero digit; digit 0 always counts as significant.
    always_comb begin
        msd = 3'd0;
        for (int n = 1; n < 6; n++) begin
            if (bcd_result[4*n +: 4] != 4'd0) msd = 3'(n);
        end
    end

    always_comb begin
        body = seg_code(digit);
        if (idx > msd) body = (sign && (idx == msd + 3'd1)) ? 7'h3F : 7'h7F;
    end
`else
    logic unused_sign;
    assign unused_sign = sign;
    assign body        = seg_code(digit);
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel <= 6'b000000;
            seg <= 8'hFF;
        end else if (seg_en) begin
            sel <= sel_next;
            seg <= {~dp, body};
        end else begin
            sel <= 6'b000000;
            seg <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_seg_dyn_scan.sv
// Scoreboard bench for seg_dyn_scan: stimulus queues expected frames from a decimal model, a monitor checks them.
`timescale 1ns/1ps
module tb_seg_dyn_scan;
    localparam logic [15:0] CNT_MAX = 16'd9;
    localparam int PERIOD = 10;
    localparam logic [6:0] ENC [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef enum logic {K_EXACT, K_FRAME} kind_t;
    typedef struct {
        kind_t       kind;
        string       name;
        logic [5:0]  sel;
        logic [7:0]  seg;
        logic [47:0] segs;
    } item_t;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic [5:0]  sel;
    logic [7:0]  seg;

    item_t q[$];
    bit    mon_busy;
    int    n_cmp;
    int    n_err;
    item_t mon_item;

    seg_dyn_scan #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .data     (data),
        .point    (point),
        .sign     (sign),
        .seg_en   (seg_en),
        .sel      (sel),
        .seg      (seg)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference: decimal digits by division, blanking decided from the most significant nonzero digit.
    function automatic logic [47:0] model_frame(input int unsigned value, input logic [5:0] pt,
                                                input logic sg);
        int unsigned v;
        int unsigned p;
        int          dig [6];
        int          m;
        logic [6:0]  body;
        logic [47:0] f;
        v = (value > 999999) ? 999999 : value;
        p = 1;
        m = 0;
        for (int i = 0; i < 6; i++) begin
            dig[i] = int'((v / p) % 10);
            if (dig[i] != 0) m = i;
            p = p * 10;
        end
        f = '0;
        for (int i = 0; i < 6; i++) begin
            body = ENC[dig[i]];
`ifdef SEG_DYN_ZERO_BLANK_EN
            if (i > m) body = (sg && i == m + 1) ? 7'h3F : 7'h7F;
`else
            if (sg && m > 5) body = 7'h7F;
`endif
            f[8*i +: 8] = {~pt[i], body};
        end
        return f;
    endfunction

    function automatic int sel_index(input logic [5:0] s);
        int r;
        r = -1;
        if ($onehot(s)) begin
            for (int i = 0; i < 6; i++) if (s[i]) r = i;
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_frame(input item_t it);
        int         cur;
        int         prev;
        int         cyc;
        logic [5:0] last;
        cur = sel_index(sel);
        check_output($sformatf("%s.onehot0", it.name), 32'($onehot(sel)), 32'd1);
        if (cur >= 0) check_output($sformatf("%s.d%0d", it.name, cur), seg, it.segs[8*cur +: 8]);
        for (int k = 1; k < 6; k++) begin
            prev = cur;
            last = sel;
            cyc  = 0;
            while (sel === last && cyc < 3 * PERIOD) begin
                @(negedge sys_clk);
                cyc++;
            end
            if (sel === last) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL %s.timeout: sel stuck at %b, required a digit change", it.name, sel);
                return;
            end
            cur = sel_index(sel);
            check_output($sformatf("%s.onehot%0d", it.name, k), 32'($onehot(sel)), 32'd1);
            if (k >= 2) check_output($sformatf("%s.period%0d", it.name, k), cyc, PERIOD);
            if (prev >= 0) check_output($sformatf("%s.step%0d", it.name, k), cur, (prev + 1) % 6);
            if (cur >= 0) check_output($sformatf("%s.d%0d", it.name, cur), seg, it.segs[8*cur +: 8]);
        end
    endtask

    // Monitor: pops one expectation per free negedge and checks what the display presents.
    initial begin
        mon_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (q.size() != 0) begin
                mon_busy = 1'b1;
                mon_item = q.pop_front();
                if (mon_item.kind == K_EXACT) begin
                    check_output({mon_item.name, ".sel"}, sel, mon_item.sel);
                    check_output({mon_item.name, ".seg"}, seg, mon_item.seg);
                end else begin
                    check_frame(mon_item);
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic push_exact(input string name, input logic [5:0] s, input logic [7:0] g);
        item_t it;
        it.kind = K_EXACT;
        it.name = name;
        it.sel  = s;
        it.seg  = g;
        it.segs = '0;
        q.push_back(it);
    endtask

    task automatic push_frame(input string name);
        item_t it;
        it.kind = K_FRAME;
        it.name = name;
        it.sel  = '0;
        it.seg  = '0;
        it.segs = model_frame(int'(data), point, sign);
        q.push_back(it);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((q.size() != 0 || mon_busy) && guard < 1000) begin
            @(negedge sys_clk);
            guard++;
        end
        if (guard >= 1000) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL scoreboard.drain: %0d items left, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic apply_stimulus(input logic [19:0] d, input logic [5:0] p, input logic s);
        @(posedge sys_clk);
        #1;
        data  = d;
        point = p;
        sign  = s;
    endtask

    task automatic settle();
        repeat (48) @(posedge sys_clk);
        #1;
    endtask

    task automatic run_case(input string name, input logic [19:0] d, input logic [5:0] p,
                            input logic s);
        apply_stimulus(d, p, s);
        settle();
        push_frame(name);
        wait_idle();
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        sys_rst_n = 1'b0;
        data      = '0;
        point     = '0;
        sign      = 1'b0;
        seg_en    = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        push_exact("reset", 6'b000000, 8'hFF);
        wait_idle();

        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        push_exact("first", 6'b000001, 8'hC0);
        wait_idle();
        settle();
        push_frame("zero");
        wait_idle();

        run_case("dec123456", 20'd123456, 6'b000000, 1'b0);
        run_case("clamp", 20'd1234567, 6'b000000, 1'b0);
        run_case("neg42", 20'd42, 6'b000010, 1'b1);
        run_case("signdrop", 20'd999999, 6'b000000, 1'b1);
        run_case("max20", 20'hFFFFF, 6'b101010, 1'b1);

        @(posedge sys_clk);
        #1;
        seg_en = 1'b0;
        @(posedge sys_clk);
        #1;
        push_exact("en_off", 6'b000000, 8'hFF);
        wait_idle();
        repeat (25) @(posedge sys_clk);
        #1;
        push_exact("en_off_hold", 6'b000000, 8'hFF);
        wait_idle();
        @(posedge sys_clk);
        #1;
        seg_en = 1'b1;
        @(posedge sys_clk);
        #1;
        push_frame("en_on");
        wait_idle();

        apply_stimulus(20'd777, 6'b000100, 1'b1);
        repeat (5) @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        push_exact("rst_mid", 6'b000000, 8'hFF);
        wait_idle();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        push_exact("rst_first", 6'b000001, 8'hC0);
        wait_idle();
        settle();
        push_frame("rst_777");
        wait_idle();

        for (int n = 0; n < 10; n++) begin
            int unsigned mode;
            logic [19:0] d;
            mode = $urandom_range(0, 2);
            if (mode == 0)      d = 20'($urandom_range(0, 999));
            else if (mode == 1) d = 20'($urandom_range(0, 999999));
            else                d = 20'($urandom_range(0, 1048575));
            run_case($sformatf("rand%0d", n), d, 6'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seg_dyn_scan.md
Name: seg_dyn_scan

Overview:
- Upstream driver for the 74HC595 display serializer. Converts a 20-bit binary value to six BCD digits with a sequential double-dabble converter.
- Time-multiplexes the digits across a 6-digit common-anode 7-segment display, with leading-zero blanking, a sign digit and per-digit decimal points.
- Produces the registered one-hot digit select `sel[5:0]` and active-low segment code `seg[7:0]` that the serializer consumes.

Parameters:
- CNT_MAX, 16'd49_999: scan tick period minus 1 in sys_clk cycles (1 ms at 50 MHz). Must be ≥ 2.

Ports:
- sys_clk  input  1  system clock
- sys_rst_n  input  1  asynchronous active-low reset
- data  input  20  unsigned value to display; values > 999_999 clamp to 999_999
- point  input  6  decimal point enables; point[i]=1 lights dp of digit i (i=0 is rightmost/units)
- sign  input  1  1 = display a minus sign
- seg_en  input  1  1 = display on; 0 = all digits dark
- sel  output  6  one-hot digit select, active-high; bit i drives digit i
- seg  output  8  segment code, active-low; seg[6:0]=g..a, seg[7]=dp

Behaviour:
- Reset (async, sys_rst_n=0):
  - Outputs: sel=6'b000000, seg=8'hFF.
  - Internal: scan counter=0, digit index=0, BCD result register=0, converter state=IDLE.
- Converter FSM, free-running, 22-cycle period:
  - IDLE (1 cycle): capture the clamped data into the shift register; clear BCD scratch; go to SHIFT.
  - SHIFT (20 cycles): each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. A 5-bit iteration counter counts 0..19 and exits to LOAD at 19.
  - LOAD (1 cycle): copy the 24-bit scratch into the BCD result register; go to IDLE.
  - Latency from data change to result register: ≤ 44 cycles.
  - A data change mid-conversion does not disturb the running conversion; the new value is picked up at the next IDLE.
- Scan timing:
  - Counter runs 0..CNT_MAX, then wraps to 0.
  - On the cycle the counter equals CNT_MAX, the digit index increments 0→5, and 5 wraps to 0.
  - sel and seg are registered from the current index and BCD result, so outputs follow an index change by 1 cycle.
  - Counters run regardless of seg_en.
- Digit content for index i:
  - Segment encoding, digits 0..9, seg[6:0] with dp off: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - Leading-zero blanking: let m = index of the highest nonzero digit (m=0 if the value is 0). Digits i > m are blanked (seg[6:0]=7'h7F). Digit 0 is always shown.
  - Sign: if sign=1 and m<5, digit m+1 shows minus (seg[6:0]=7'h3F). If m=5, the sign is dropped.
  - Decimal point: seg[7] = ~point[i]. Applies on blanked and sign digits too.
- seg_en=0: sel=6'b000000, seg=8'hFF, effective on the next registered update (1 cycle).
- sel is exactly one-hot whenever seg_en=1; never more than one bit set.
- A reset asserted mid-scan or mid-conversion returns everything to the reset values immediately. The display stays dark (sel=0) until the first registered update after release, which is the first cycle after release.

Optional Feature:
- Macro: SEG_DYN_ZERO_BLANK_EN.
- Defined: leading-zero blanking and the sign digit behave as described in Behaviour.
- Undefined:
  - All six digits always show their BCD value, including leading zeros.
  - The sign input is ignored (no minus drawn).
  - The blanking/sign logic is not synthesized.
  - Decimal points are unchanged.

Test Plan (CNT_MAX=9 in simulation):
1. Reset held, then released with data=0, seg_en=1 → sel=000000/seg=FF during reset. After release, digit 0 shows C0 and the other digits show FF. The index steps every 10 cycles with sel = 000001, 000010, …, 100000, then wraps to 000001.
2. data=123456, point=0, sign=0 → after ≤44 cycles, digits 5..0 show F9, A4, B0, 99, 92, 82.
3. data=1234567 (clamp) → all six digits show 90 (999999). Then data=42, sign=1, point=6'b000010 → digit 0 shows A4, digit 1 shows 19 (4 with dp lit), digit 2 shows BF (minus), digits 3..5 show FF.
4. data=999999, sign=1 → sign dropped: no digit shows BF, and all digits show 90.
5. seg_en toggled 1→0→1 mid-scan → sel=000000/seg=FF one cycle after the drop. The scan index keeps advancing while off, and display resumes at the current index one cycle after re-enable.
6. Reset pulsed mid-SHIFT with data=777 → outputs return to reset values asynchronously. After release, 777 is displayed correctly within 44 cycles. With SEG_DYN_ZERO_BLANK_EN undefined, digits 5..3 show C0.
